ctrl_rr_arbiter: RTL
====================

# ctrl_rr_arbiter

Round-robin owner arbiter for the shared control bus. Up to N_REQ requesters raise REQUEST; the block grants exactly one with a one-hot EN and holds the grant for the owner's full BUSY tenure. On BUSY's falling edge it releases the bus and rotates priority, so no requester can starve. It sits between the loader requesters and the shared bus mux, and drives the mux select (OWNER) directly.

## Interface
- N_REQ, 8: number of requesters, 2..16
- START_TIMEOUT, 16: cycles allowed from grant to BUSY rise (watchdog only)
- MAX_HOLD, 1024: maximum cycles BUSY may stay high (watchdog only)
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- REQUEST  in  N_REQ  level request per requester
- BUSY  in  N_REQ  per-requester busy; only the owner's bit is observed
- EN  out  N_REQ  one-hot grant; all zero when no owner
- OWNER  out  clog2(N_REQ)  index of current owner, 0 when idle
- ACTIVE  out  1  high while a grant is outstanding (EN != 0)
- TIMEOUT  out  1  one-cycle pulse on watchdog abort

## Operation
- Reset values: EN=0, OWNER=0, ACTIVE=0, TIMEOUT=0, PTR=0, CNT=0, state IDLE.
- States: IDLE, GRANT (granted, waiting for BUSY rise), OWN (BUSY high), RELEASE (one-cycle bus gap).
- IDLE: if REQUEST!=0, pick the first set bit searching upward from PTR with wrap; load OWNER, set EN=onehot(OWNER), go to GRANT, CNT=0.
- GRANT: BUSY[OWNER]=1 -> OWN, CNT=0. REQUEST[OWNER]=0 with BUSY low -> RELEASE (withdrawal, no TIMEOUT). Otherwise CNT increments.
- OWN: BUSY[OWNER]=0 -> RELEASE; REQUEST changes are ignored. Otherwise CNT increments.
- RELEASE: EN=0 and ACTIVE=0 for this cycle; PTR = OWNER+1, wrapping N_REQ-1 to 0; OWNER=0. Go to IDLE.
- CNT width is clog2(MAX_HOLD+1) and saturates; it never wraps.
- BUSY bits of non-owners are don't-care at all times.
- A reset asserted mid-tenure returns every output to its reset value on the next edge. There is no release sequence.

## Timing
- REQUEST sampled high in IDLE at edge k -> EN/OWNER/ACTIVE valid after edge k (one-cycle latency).
- BUSY[OWNER] fall sampled at edge m -> state RELEASE and EN=0 after edge m; IDLE after m+1; next grant earliest after m+2.
- Minimum tenure is 3 cycles (GRANT, OWN, RELEASE). Back-to-back grants to different requesters are always separated by one EN=0 cycle.
- Simultaneous requests: the lowest index at or above PTR wins, wrapping.
- A requester holding REQUEST continuously is re-granted only after every other active requester has been served once.

## Configuration
- Macro ARB_WATCHDOG_EN.
- With the macro defined:
  - In GRANT, CNT reaching START_TIMEOUT-1 without BUSY moves to RELEASE.
  - In OWN, CNT reaching MAX_HOLD-1 moves to RELEASE.
  - In both cases TIMEOUT pulses high for the RELEASE cycle, and PTR rotates past the faulty owner.
- Without the macro: GRANT and OWN wait indefinitely, TIMEOUT is tied 0, CNT logic is removed, and START_TIMEOUT/MAX_HOLD are unused.

## Structure
- Shared package ctrl_pkg holds:
  - the state encoding (IDLE=0, GRANT=1, OWN=2, RELEASE=3)
  - the N_REQ default
  - a clog2-based width constant for OWNER
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: REQUEST vector and PTR.
  - Outputs: the index and a valid flag.
  - Instantiated once.
- The FSM, counter and pointer live in the top.

## Test plan
- Single requester: REQUEST=0x04 at edge 1, BUSY[2] high for edges 3-7 -> EN=0x04 after edge 1, RELEASE after edge 8, EN=0 and PTR=3.
- Contention: REQUEST=0x81 held, each tenure 4 cycles BUSY -> grant order 0,7,0,7 with one EN=0 gap between tenures.
- Wrap: PTR=7, REQUEST=0x03 -> owner 0 granted; after release PTR=1, next owner 1.
- Withdrawal: grant to 5, REQUEST[5] drops before BUSY rises -> RELEASE next cycle, TIMEOUT stays 0.
- Watchdog (ARB_WATCHDOG_EN, START_TIMEOUT=16): grant to 3, BUSY never rises -> TIMEOUT pulse 16 cycles after grant, EN=0, PTR=4. Without the macro, EN=0x08 holds indefinitely.
- Reset mid-OWN: RESET high for one edge while owner 6 is busy -> EN=0, OWNER=0, ACTIVE=0, PTR=0 after that edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-bus round-robin arbiter (optional ARB_WATCHDOG_EN).
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int N_REQ_DEF = 8;
    localparam int OWNER_W   = $clog2(N_REQ_DEF);

endpackage

// File: rtl/ctrl_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping.
module rr_pick
    import ctrl_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int OW = OWNER_W
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] ptr,
    output logic [OW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = OW'(j);
            end
        end
    end

endmodule

// File: rtl/ctrl_rr_arbiter.sv
// Round-robin bus-owner arbiter; define ARB_WATCHDOG_EN to enable the start/hold watchdog.
module ctrl_rr_arbiter
    import ctrl_pkg::*;
#(
    parameter int N_REQ         = N_REQ_DEF,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_HOLD      = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         REQUEST,
    input  logic [N_REQ-1:0]         BUSY,
    output logic [N_REQ-1:0]         EN,
    output logic [$clog2(N_REQ)-1:0] OWNER,
    output logic                     ACTIVE,
    output logic                     TIMEOUT
);

    localparam int OW = $clog2(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > 16 || START_TIMEOUT < 1 || MAX_HOLD < 1) begin : g_bad_param
            $error("ctrl_rr_arbiter: parameter out of range");
        end
    endgenerate

    state_t        state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] pick_idx;
    logic          pick_vld;
    logic [OW-1:0] ptr_next;
    logic          rel;

    rr_pick #(.N(N_REQ), .OW(OW)) u_pick (
        .req   (REQUEST),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign ptr_next = (OWNER == OW'(N_REQ - 1)) ? '0 : OWNER + 1'b1;

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt;
    logic          wd;
    logic          timeout_q;
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    // BUSY rising in GRANT wins over a simultaneous request withdrawal.
    always_comb begin
        rel = 1'b0;
`ifdef ARB_WATCHDOG_EN
        wd  = 1'b0;
`endif
        case (state)
            ST_GRANT: if (!BUSY[OWNER]) begin
                if (!REQUEST[OWNER]) rel = 1'b1;
`ifdef ARB_WATCHDOG_EN
                else if (cnt == CW'(START_TIMEOUT - 1)) begin rel = 1'b1; wd = 1'b1; end
`endif
            end
            ST_OWN: begin
                if (!BUSY[OWNER]) rel = 1'b1;
`ifdef ARB_WATCHDOG_EN
                else if (cnt == CW'(MAX_HOLD - 1)) begin rel = 1'b1; wd = 1'b1; end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            OWNER  <= '0;
            EN     <= '0;
            ACTIVE <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            cnt       <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: if (pick_vld) begin
                    state  <= ST_GRANT;
                    OWNER  <= pick_idx;
                    EN     <= N_REQ'(1) << pick_idx;
                    ACTIVE <= 1'b1;
`ifdef ARB_WATCHDOG_EN
                    cnt    <= '0;
`endif
                end
                ST_GRANT, ST_OWN: begin
                    if (rel) begin
                        // Pointer rotates past the owner whatever the release cause.
                        state  <= ST_RELEASE;
                        EN     <= '0;
                        ACTIVE <= 1'b0;
                        OWNER  <= '0;
                        ptr    <= ptr_next;
`ifdef ARB_WATCHDOG_EN
                        timeout_q <= wd;
`endif
                    end else if (state == ST_GRANT && BUSY[OWNER]) begin
                        state <= ST_OWN;
`ifdef ARB_WATCHDOG_EN
                        cnt   <= '0;
`endif
                    end
`ifdef ARB_WATCHDOG_EN
                    else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
